layer1_6_mac_engine: RTL

Compute stage directly downstream of the layer-1 group-6 weight loader. Once the loader raises `done`, this block takes the flat weight bus and a flat input-activation vector. It runs OUT_SIZE parallel signed multiply-accumulates over IN_SIZE cycles, then applies shift, ReLU and saturation, and presents OUT_SIZE 8-bit activations to the next layer with a start/done handshake.

---
 rtl/layer1_6_mac_engine.sv | 107 ++++++++++
 1 files changed

// File: rtl/layer1_6_mac_engine.sv
// Layer-1 group-6 MAC engine: OUT_SIZE parallel signed MACs over IN_SIZE inputs,
// followed by arithmetic shift, ReLU and saturation to W-bit activations.
module layer1_6_mac_engine #(
    parameter int unsigned IN_SIZE       = 256,
    parameter int unsigned OUT_SIZE      = 8,
    parameter int unsigned W             = 8,
    parameter int unsigned ACC_W         = 24,
    parameter int unsigned SHIFT         = 7,
    parameter int unsigned TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [TOTAL_WEIGHTS*W-1:0] weights_i,
    input  logic [IN_SIZE*W-1:0]       data_in_i,
    output logic [OUT_SIZE*W-1:0]      data_out_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned IDX_W = $clog2(IN_SIZE) + 1;
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(IN_SIZE);
    localparam logic signed [ACC_W-1:0] SatHi = ACC_W'((1 << (W - 1)) - 1);

    typedef enum logic [1:0] {StIdle, StMac, StFinish, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q [OUT_SIZE];
    logic signed [ACC_W-1:0] acc_d [OUT_SIZE];
    logic [OUT_SIZE*W-1:0]   dout_q, dout_d;

    logic signed [W-1:0]     w_sel;
    logic signed [W-1:0]     d_sel;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] r;

    // Next-state logic for the FSM, accumulators, index and output register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        for (int j = 0; j < OUT_SIZE; j++) acc_d[j] = acc_q[j];
        w_sel   = '0;
        prod    = '0;
        r       = '0;
        d_sel   = data_in_i[int'(idx_q)*W +: W];

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    for (int j = 0; j < OUT_SIZE; j++) acc_d[j] = '0;
                    idx_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                // idx reaches IN_SIZE after the last update; that cycle is spent
                // handing over to FINISH, so done lands IN_SIZE+2 edges after start.
                if (idx_q == IdxLast) begin
                    state_d = StFinish;
                end else begin
                    for (int j = 0; j < OUT_SIZE; j++) begin
                        w_sel    = weights_i[(j * IN_SIZE + int'(idx_q)) * W +: W];
                        prod     = (2*W)'(w_sel) * (2*W)'(d_sel);
                        acc_d[j] = acc_q[j] + ACC_W'(prod);
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            StFinish: begin
                for (int j = 0; j < OUT_SIZE; j++) begin
                    r = acc_q[j] >>> SHIFT;
                    if (r[ACC_W-1]) begin
                        dout_d[j*W +: W] = '0;
                    end else if (r > SatHi) begin
                        dout_d[j*W +: W] = SatHi[W-1:0];
                    end else begin
                        dout_d[j*W +: W] = r[W-1:0];
                    end
                end
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dout_q  <= '0;
            for (int j = 0; j < OUT_SIZE; j++) acc_q[j] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            for (int j = 0; j < OUT_SIZE; j++) acc_q[j] <= acc_d[j];
        end
    end

    assign data_out_o = dout_q;
    assign busy_o     = (state_q == StMac) || (state_q == StFinish);
    assign done_o     = (state_q == StDone);

endmodule
